// File: rtl/register_bus_master.sv
// register_bus_master: decodes UART read/write command packets into register bus cycles
// and returns read data to the UART transmitter as four little-endian bytes.
module register_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        ipClk,
    input  logic        Reset,
    input  logic [7:0]  ipRxData,
    input  logic        ipRxValid,
    output logic [7:0]  opTxData,
    output logic        opTxValid,
    input  logic        ipTxReady,
    output logic [7:0]  opAddress,
    output logic [31:0] opWrData,
    output logic        opWrEnable,
    input  logic [31:0] ipRdData,
    output logic        opBusy
);
    typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WRITE, RD_WAIT, SEND} state_t;

    state_t      state, nextState;
    logic        isWrite;
    logic [1:0]  byteCnt, waitCnt;
    logic [31:0] toCnt;
    logic [23:0] rdShift;
    logic        receiving, timedOut, txFire;

    assign receiving = state == GET_ADDR || state == GET_DATA;
    assign timedOut  = !ipRxValid && toCnt == TIMEOUT_CYCLES - 1;
    assign txFire    = opTxValid && ipTxReady;

    always_ff @(posedge ipClk) state <= Reset ? IDLE : nextState;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     nextState = ipRxValid && ipRxData[7:1] == 7'd0 ? GET_ADDR : IDLE;
            GET_ADDR: nextState = ipRxValid ? (isWrite ? GET_DATA : RD_WAIT) : timedOut ? IDLE : GET_ADDR;
            GET_DATA: nextState = ipRxValid ? (byteCnt == 2'd3 ? WRITE : GET_DATA) : timedOut ? IDLE : GET_DATA;
            WRITE:    nextState = IDLE;
            RD_WAIT:  nextState = waitCnt == 2'd2 ? SEND : RD_WAIT;
            SEND:     nextState = txFire && byteCnt == 2'd3 ? IDLE : SEND;
            default:  nextState = IDLE;
        endcase
    end

    // Busy and write strobe follow the next state so they line up with the FSM as registers.
    always_ff @(posedge ipClk) begin
        if (Reset) begin
            opBusy     <= 1'b0;
            opWrEnable <= 1'b0;
            opAddress  <= 8'd0;
            opWrData   <= 32'd0;
            opTxData   <= 8'd0;
            opTxValid  <= 1'b0;
            isWrite    <= 1'b0;
            byteCnt    <= 2'd0;
            waitCnt    <= 2'd0;
            toCnt      <= 32'd0;
            rdShift    <= 24'd0;
        end else begin
            opBusy     <= nextState != IDLE;
            opWrEnable <= nextState == WRITE;
            toCnt      <= receiving && !ipRxValid ? toCnt + 32'd1 : 32'd0;
            case (state)
                IDLE: if (ipRxValid) isWrite <= ipRxData[0];
                GET_ADDR: if (ipRxValid) begin
                    opAddress <= ipRxData;
                    byteCnt   <= 2'd0;
                    waitCnt   <= 2'd0;
                end
                GET_DATA: if (ipRxValid) begin
                    opWrData[8*byteCnt +: 8] <= ipRxData;
                    byteCnt                  <= byteCnt + 2'd1;
                end
                RD_WAIT: begin
                    waitCnt <= waitCnt + 2'd1;
                    if (waitCnt == 2'd2) begin
                        rdShift   <= ipRdData[31:8];
                        opTxData  <= ipRdData[7:0];
                        opTxValid <= 1'b1;
                    end
                end
                SEND: if (txFire) begin
                    rdShift  <= rdShift >> 8;
                    opTxData <= rdShift[7:0];
                    byteCnt  <= byteCnt + 2'd1;
                    if (byteCnt == 2'd3) opTxValid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/register_bus_master.md
# register_bus_master

Initiator end of the 8-bit-address / 32-bit-data memory-mapped register bus. Takes a byte stream from the UART receiver, decodes read and write command packets, and drives the register bus. Returns read data to the UART transmitter as four bytes. Sits between the UART RX/TX blocks and the register block, making every register host-accessible.

## Interface

- TIMEOUT_CYCLES, 1_000_000: inter-byte timeout inside a packet, in ipClk cycles (20 ms at 50 MHz); must fit in 32 bits, minimum 1.
- ipClk  input  1  clock; all logic on rising edge.
- Reset  input  1  reset Reset, synchronous, active-high; clock ipClk.
- ipRxData  input  8  received byte; valid only when ipRxValid=1.
- ipRxValid  input  1  single-cycle strobe per received byte; no backpressure.
- opTxData  output  8  byte to transmit.
- opTxValid  output  1  opTxData valid; held until accepted.
- ipTxReady  input  1  transmitter accepts the byte in any cycle where opTxValid and ipTxReady are both 1.
- opAddress  output  8  register bus address.
- opWrData  output  32  register bus write data.
- opWrEnable  output  1  register bus write strobe.
- ipRdData  input  32  register bus read data; registered by the responder one cycle after opAddress.
- opBusy  output  1  high whenever the FSM is not in IDLE.

## Operation

Packet format; multi-byte fields are little-endian:
- Read: 0x00, addr. Response: 4 bytes of read data, LSB first.
- Write: 0x01, addr, d0, d1, d2, d3. No response.
- Any other command byte is discarded and the FSM stays in IDLE.

States and transitions:
- IDLE: on ipRxValid with 0x00 or 0x01, latch the command and go to GET_ADDR.
- GET_ADDR: on ipRxValid, load opAddress. A read goes to RD_WAIT; a write goes to GET_DATA with byte count 0.
- GET_DATA: on each ipRxValid, shift the byte into opWrData[8k+7:8k] for k = 0..3. After k=3, go to WRITE.
- WRITE: opWrEnable=1 for exactly this one cycle, then IDLE.
- RD_WAIT: 2 cycles, then capture ipRdData into a 32-bit shift register and go to SEND with count 0.
- SEND: present byte k (k = 0..3) with opTxValid=1. On the handshake, advance k. After k=3 is accepted, drop opTxValid and go to IDLE.

Rules:
- Timeout counter resets to 0 on every accepted RX byte and increments in GET_ADDR and GET_DATA. When it reaches TIMEOUT_CYCLES, go to IDLE: the partial packet is dropped, no bus cycle is issued, and opAddress/opWrData keep their partial values.
- No timeout in SEND. A transmitter stall holds the FSM indefinitely.
- ipRxValid in WRITE, RD_WAIT or SEND is ignored; the byte is lost.
- opTxData stays stable while opTxValid=1 and ipTxReady=0.
- opAddress and opWrData hold their last values in IDLE. opWrEnable is 1 only in WRITE.
- Reset values: opAddress=0, opWrData=0, opWrEnable=0, opTxData=0, opTxValid=0, opBusy=0, state IDLE, counters 0.
- Reset in any state returns to IDLE on the next edge. Any pending write or read response is abandoned, and opTxValid and opWrEnable are 0 in the cycle after Reset is sampled.

## Timing

- All outputs are registered.
- Write: last data strobe in cycle N. opWrEnable=1 with final opAddress/opWrData in cycle N+1, and opBusy=0 from N+2.
- Read: address strobe in cycle N.
  - opAddress is valid from N+1; the responder registers the data at the end of N+2.
  - The master captures ipRdData at the end of N+3, and the first opTxValid appears in N+4.
- Back-to-back bytes (strobes every cycle) are accepted in all receive states.
- A new command is accepted in the cycle after the FSM returns to IDLE.
- Send throughput is one byte per cycle while ipTxReady=1.
- Timeout: with the last strobe in cycle N, the FSM is in IDLE at N+TIMEOUT_CYCLES+1.

## Test plan

- Write packet 01 02 78 56 34 12 at one strobe per 10 cycles -> one opWrEnable pulse with opAddress=0x02, opWrData=0x12345678. No TX output.
- Read packet 00 00, responder model returning 0xCAFEBABE at address 0, ipTxReady tied 1 -> TX bytes BE, BA, FE, CA on 4 consecutive cycles, first byte 4 cycles after the address strobe.
- Read with ipTxReady toggling every 3 cycles -> opTxData stable while stalled, all 4 bytes in order, no duplicates.
- Invalid command 0x7F, then a valid write to 0x02 -> 0x7F ignored and the write completes normally.
- Write 01 02 AA, then silence with TIMEOUT_CYCLES=100 -> opBusy=0 after 101 cycles and no opWrEnable. A following full write succeeds.
- Reset asserted mid-SEND (after byte 1 accepted) -> opTxValid=0 and opBusy=0 the next cycle. A subsequent read returns all 4 bytes.
